fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO that supersedes the fixed 8-bit FIFO in the memory library. Configurable data width and power-of-two depth, with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 2^DEPTH_LOG2 (≥1)
- AF_LEVEL, 14, AlmostFull asserted when Count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, AlmostEmpty asserted when Count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- Din  in  WIDTH  write data, sampled when a write is accepted
- WR_EN  in  1  write request
- RD_EN  in  1  read request (FWFT: pop/acknowledge of head word)
- CLR_ERR  in  1  synchronous clear of Overflow and Underflow
- Dout  out  WIDTH  read data
- Valid  out  1  Dout holds a valid word (see Operation)
- Empty  out  1  Count == 0
- Full  out  1  Count == DEPTH
- AlmostFull  out  1  Count ≥ AF_LEVEL
- AlmostEmpty  out  1  Count ≤ AE_LEVEL
- Count  out  DEPTH_LOG2+1  words currently stored
- Overflow  out  1  sticky: a write was attempted while Full and not accepted
- Underflow  out  1  sticky: a read was attempted while Empty

## Operation
- Storage: DEPTH×WIDTH ring buffer; write and read pointers DEPTH_LOG2 bits, wrap modulo DEPTH naturally.
- Write accepted when WR_EN && (!Full || rd_accept). Stores Din at wr_ptr, wr_ptr+1.
- Read accepted (rd_accept) when RD_EN && !Empty. rd_ptr+1.
- Count next = Count + wr_accept − rd_accept; Empty/Full/AlmostFull/AlmostEmpty are registered and derived from next Count, so they are exact in the cycle after the edge.
- Simultaneous read+write:
  - Empty: write accepted, read rejected, Underflow set; Count 0→1.
  - Full: both accepted, Count stays DEPTH, Overflow not set; read returns the old head word, new word lands in the freed slot.
  - Otherwise: both accepted, Count unchanged.
- Write while Full without accepted read: dropped, Overflow set, pointers/Count unchanged.
- Standard mode (FWFT=0): on accepted read, Dout ← head word at next edge, Valid high for exactly that one cycle; Dout otherwise holds last value.
- FWFT mode (FWFT=1): Dout continuously shows head word (mem[rd_ptr]); Valid = !Empty; RD_EN consumes the displayed word. Dout is don't-care when Empty.
- Error flags: set as above, remain set until CLR_ERR sampled high or reset. Set in the same cycle as CLR_ERR: set wins.
- Storage contents are not reset.

## Timing
- Reset (RST low, asynchronous): pointers 0, Count 0, Empty 1, Full 0, AlmostEmpty 1, AlmostFull 0, Overflow 0, Underflow 0, Valid 0, Dout 0 (standard mode). Reset mid-transfer discards all stored words; first edge after RST deasserts is a normal cycle.
- Write-to-Empty-deassert: 1 cycle. Write-to-read-visible: standard mode data on Dout 1 cycle after RD_EN edge; FWFT head visible 1 cycle after the write edge.
- Read-to-Full-deassert: 1 cycle.
- Full throughput: one write and one read per cycle sustained.
- Pointer wrap: after DEPTH writes wr_ptr returns to 0 with no gap or bubble.

## Test plan
- Reset then write 0..15 (WIDTH=8, DEPTH_LOG2=4), one per cycle -> Count 16, Full 1, AlmostFull 1 from Count 14; read 16 -> Dout 0..15 in order, each with Valid pulse, Empty 1 at end.
- Fill to 16, write 0xAA with RD_EN low -> Overflow 1, Count 16, 0xAA never read; CLR_ERR pulse -> Overflow 0.
- Empty FIFO, RD_EN and WR_EN Din=0x5A same cycle -> Underflow 1, Count 1, next read returns 0x5A.
- Full FIFO, simultaneous RD_EN/WR_EN Din=0x77 for 20 cycles -> Count stays 16, no Overflow, read stream continuous, pointer wrap correct, 0x77 words read out in order afterwards.
- FWFT=1: write 0x11,0x22 -> Dout 0x11 with Valid 1 one cycle after first write, no RD_EN needed; RD_EN -> Dout 0x22; second RD_EN -> Empty 1, Valid 0.
- Write 5 words, assert RST low asynchronously between edges -> all outputs immediately at reset values; after release, write 0x33 and read -> Dout 0x33 (old data gone).

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and optional first-word-fall-through output.
module fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      Din,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  input  logic                  CLR_ERR,
  output logic [WIDTH-1:0]      Dout,
  output logic                  Valid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_COUNT   = CNT_W'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0] AE_COUNT   = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  empty_q;
  logic                  full_q;
  logic                  almost_full_q;
  logic                  almost_empty_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  overflow_set;
  logic                  underflow_set;

  // A read frees a slot in the same edge, so a full FIFO can still accept a write.
  assign rd_accept     = RD_EN && !empty_q;
  assign wr_accept     = WR_EN && (!full_q || rd_accept);
  assign overflow_set  = WR_EN && full_q && !rd_accept;
  assign underflow_set = RD_EN && empty_q;

  always_comb begin
    count_next = count_q;
    if (wr_accept && !rd_accept)
      count_next = count_q + 1'b1;
    else if (rd_accept && !wr_accept)
      count_next = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (wr_accept)
      mem[wr_ptr] <= Din;
  end

  // Status flags are registered from the next count so they are exact after each edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept)
        rd_ptr <= rd_ptr + 1'b1;
      count_q        <= count_next;
      empty_q        <= (count_next == '0);
      full_q         <= (count_next == FULL_COUNT);
      almost_full_q  <= (count_next >= AF_COUNT);
      almost_empty_q <= (count_next <= AE_COUNT);
      overflow_q     <= overflow_set  || (overflow_q  && !CLR_ERR);
      underflow_q    <= underflow_set || (underflow_q && !CLR_ERR);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign Dout  = mem[rd_ptr];
      assign Valid = !empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept)
            dout_q <= mem[rd_ptr];
        end
      end

      assign Dout  = dout_q;
      assign Valid = valid_q;
    end
  endgenerate

  assign Empty       = empty_q;
  assign Full        = full_q;
  assign AlmostFull  = almost_full_q;
  assign AlmostEmpty = almost_empty_q;
  assign Count       = count_q;
  assign Overflow    = overflow_q;
  assign Underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a standard-mode instance checked every cycle
// against a queue model, plus a first-word-fall-through instance.
module tb_fifo_param;

  logic       clock;
  logic       reset;

  logic [7:0] din;
  logic       wrEn;
  logic       rdEn;
  logic       clrErr;
  logic [7:0] dout;
  logic       valid;
  logic       empty;
  logic       full;
  logic       almostFull;
  logic       almostEmpty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] fDin;
  logic       fWrEn;
  logic       fRdEn;
  logic [7:0] fDout;
  logic       fValid;
  logic       fEmpty;
  logic       fFull;
  logic       fAlmostFull;
  logic       fAlmostEmpty;
  logic [4:0] fCount;
  logic       fOverflow;
  logic       fUnderflow;

  logic [7:0] mdlQ[$];
  logic [7:0] expQ[$];
  logic [7:0] fwftQ[$];
  logic [7:0] lastDout;
  logic       mdlOvf;
  logic       mdlUdf;
  int         checkCount;
  int         errorCount;

  fifo_param dutStd (
    .CLK(clock), .RST(reset), .Din(din), .WR_EN(wrEn), .RD_EN(rdEn),
    .CLR_ERR(clrErr), .Dout(dout), .Valid(valid), .Empty(empty), .Full(full),
    .AlmostFull(almostFull), .AlmostEmpty(almostEmpty), .Count(count),
    .Overflow(overflow), .Underflow(underflow)
  );

  fifo_param #(.FWFT(1)) dutFwft (
    .CLK(clock), .RST(reset), .Din(fDin), .WR_EN(fWrEn), .RD_EN(fRdEn),
    .CLR_ERR(1'b0), .Dout(fDout), .Valid(fValid), .Empty(fEmpty), .Full(fFull),
    .AlmostFull(fAlmostFull), .AlmostEmpty(fAlmostEmpty), .Count(fCount),
    .Overflow(fOverflow), .Underflow(fUnderflow)
  );

  // Free-running 10-unit clock shared by both instances.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against anything that would keep the run from reaching its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Status outputs of the standard instance against the model occupancy and flags.
  task automatic checkState();
    int n;
    n = mdlQ.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("full", 32'(full), 32'(n == 16));
    checkOutput("almostFull", 32'(almostFull), 32'(n >= 14));
    checkOutput("almostEmpty", 32'(almostEmpty), 32'(n <= 2));
    checkOutput("overflow", 32'(overflow), 32'(mdlOvf));
    checkOutput("underflow", 32'(underflow), 32'(mdlUdf));
    checkOutput("dout", 32'(dout), 32'(lastDout));
  endtask

  // Drive one cycle on the standard instance; reads push their expected word into the scoreboard.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] data, input logic clr);
    logic rdAcc;
    logic wrAcc;
    logic ovfSet;
    logic udfSet;
    wrEn   = wr;
    rdEn   = rd;
    din    = data;
    clrErr = clr;
    rdAcc  = rd && (mdlQ.size() != 0);
    wrAcc  = wr && ((mdlQ.size() < 16) || rdAcc);
    ovfSet = wr && (mdlQ.size() == 16) && !rdAcc;
    udfSet = rd && (mdlQ.size() == 0);
    if (rdAcc) expQ.push_back(mdlQ.pop_front());
    if (wrAcc) mdlQ.push_back(data);
    mdlOvf = ovfSet || (mdlOvf && !clr);
    mdlUdf = udfSet || (mdlUdf && !clr);
    @(posedge clock);
    #1;
    checkOutput("valid", 32'(valid), 32'(rdAcc));
    if (valid && expQ.size() > 0) lastDout = expQ.pop_front();
    checkState();
  endtask

  task automatic applyIdle();
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    clrErr = 1'b0;
    fWrEn  = 1'b0;
    fRdEn  = 1'b0;
  endtask

  task automatic applyFwft(input logic wr, input logic rd, input logic [7:0] data);
    fWrEn = wr;
    fRdEn = rd;
    fDin  = data;
    if (rd && fwftQ.size() != 0) void'(fwftQ.pop_front());
    if (wr && fwftQ.size() < 16) fwftQ.push_back(data);
    @(posedge clock);
    #1;
    checkOutput("fwftValid", 32'(fValid), 32'(fwftQ.size() != 0));
    checkOutput("fwftEmpty", 32'(fEmpty), 32'(fwftQ.size() == 0));
    checkOutput("fwftCount", 32'(fCount), 32'(fwftQ.size()));
    if (fwftQ.size() != 0) checkOutput("fwftDout", 32'(fDout), 32'(fwftQ[0]));
  endtask

  task automatic clearModel();
    mdlQ.delete();
    expQ.delete();
    fwftQ.delete();
    lastDout = 8'h00;
    mdlOvf   = 1'b0;
    mdlUdf   = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    din  = 8'h00;
    fDin = 8'h00;
    applyIdle();
    clearModel();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetValid", 32'(valid), 32'(0));
    checkState();
    #3 reset = 1'b1;

    // Fill in order, then drain and expect the same order back.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    // Overflow on a dropped write, then clear it and drain the survivors.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    // Read and write together on an empty FIFO.
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Sustained read+write while full across pointer wrap.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset between edges with words still stored.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h94, 1'b0);
    applyIdle();
    #2 reset = 1'b0;
    #1;
    clearModel();
    checkOutput("asyncResetValid", 32'(valid), 32'(0));
    checkState();
    #2 reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // First-word-fall-through instance.
    applyIdle();
    applyFwft(1'b1, 1'b0, 8'h11);
    applyFwft(1'b1, 1'b0, 8'h22);
    applyFwft(1'b0, 1'b1, 8'h00);
    applyFwft(1'b0, 1'b1, 8'h00);
    applyFwft(1'b0, 1'b0, 8'h00);
    applyIdle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
